hs_sync_bridge: RTL and testbench

HS_SYNC_BRIDGE -- requirements
Module: hs_sync_bridge

---
 rtl/hs_sync_bridge.sv | 126 ++++++++++++
 tb/tb_hs_sync_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_bridge.sv
// Four-phase req/ack receiver feeding a circular FIFO with a valid/ready output side.
// Define HS_SYNC_BRIDGE_SYNC3_EN for a three-stage req_i synchronizer (default two).
module hs_sync_bridge #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ack_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef HS_SYNC_BRIDGE_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        ACK
    } state_e;

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic [SYNC_N-1:0]   sync_q, sync_d;
    logic [SYNC_N-1:0]   prime_q, prime_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic req_s;
    logic sync_ok;
    logic full;
    logic empty;
    logic wr_en;
    logic pop;

    assign req_s   = sync_q[SYNC_N-1];
    // The synchronizer resets to 0, so its output only reflects req_i once the
    // chain has been refilled; ARM ignores req_s until then.
    assign sync_ok = prime_q[SYNC_N-1];
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop     = !empty && ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        ack_d    = ack_q;
        wr_en    = 1'b0;
        sync_d   = {sync_q[SYNC_N-2:0], req_i};
        prime_d  = {prime_q[SYNC_N-2:0], 1'b1};

        case (state_q)
            ARM: begin
                ack_d = 1'b0;
                if (sync_ok && !req_s) state_d = IDLE;
            end
            IDLE: begin
                ack_d = 1'b0;
                if (req_s && !full) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ARM;
            end
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARM;
            ack_q    <= 1'b0;
            sync_q   <= '0;
            prime_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            sync_q   <= sync_d;
            prime_q  <= prime_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; its contents are don't-care until written, and valid_o masks them.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    assign ack_o   = ack_q;
    assign valid_o = !empty;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: tb/tb_hs_sync_bridge.sv
// Self-checking bench for hs_sync_bridge: latency vector table, fill/drain,
// wrap-around with a toggling consumer, and reset in the middle of a handshake.
module tb_hs_sync_bridge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef HS_SYNC_BRIDGE_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    typedef struct {
        logic             req;
        logic             ready;
        logic             chk_ack;
        logic             ack;
        logic             valid;
        logic [LVL_W-1:0] level;
    } vec_t;

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [LVL_W-1:0]  level_o;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    logic [DATA_W-1:0] sb_q [$];
    vec_t vecs [$];

    hs_sync_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .level_o (level_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string name);
        int n = 0;
        while (ack_o !== val && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(ack_o), 32'(val));
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (valid_o !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(valid_o), 32'd0);
    endtask

    task automatic xfer(input logic [DATA_W-1:0] d);
        data_i = d;
        sb_q.push_back(d);
        req_i = 1'b1;
        wait_ack(1'b1, "xfer_ack_up");
        req_i = 1'b0;
        wait_ack(1'b0, "xfer_ack_down");
    endtask

    task automatic add_vec(input logic req, input logic ready, input logic chk_ack,
                           input logic ack, input logic valid, input logic [LVL_W-1:0] level);
        vec_t v;
        v.req = req; v.ready = ready; v.chk_ack = chk_ack;
        v.ack = ack; v.valid = valid; v.level = level;
        vecs.push_back(v);
    endtask

    // Scoreboard: a pop happens on the next rising edge whenever valid_o && ready_i here.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_pop: got 0x%0h expected no word", data_o);
            end else begin
                check("sb_data", data_o, sb_q.pop_front());
            end
            pop_cnt++;
        end
    end

    initial begin
        bit done;
        int pops_before;

        rst_ni = 1'b0;
        req_i  = 1'b0;
        ready_i = 1'b0;
        data_i = '0;
        #2;
        check("reset_ack", 32'(ack_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_level", 32'(level_o), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (SYNC_N + 3) tick();

        // Single transfer: capture on edge SYNC_N+1, pop on the next edge,
        // ack stays up at least one edge after req_i drops and is down by edge SYNC_N+1.
        for (int i = 0; i < SYNC_N; i++) add_vec(1, 1, 1, 0, 0, 0);
        add_vec(1, 1, 1, 1, 1, 1);
        add_vec(1, 1, 1, 1, 0, 0);
        add_vec(0, 1, 1, 1, 0, 0);
        for (int i = 1; i < SYNC_N; i++) add_vec(0, 1, 0, 0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0);

        data_i = 32'hA5A5_0001;
        sb_q.push_back(32'hA5A5_0001);
        for (int i = 0; i < vecs.size(); i++) begin
            req_i   = vecs[i].req;
            ready_i = vecs[i].ready;
            tick();
            if (vecs[i].chk_ack) check($sformatf("vec%0d_ack", i), 32'(ack_o), 32'(vecs[i].ack));
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].valid));
            check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].level));
        end
        ready_i = 1'b0;

        // Fill to DEPTH, then a fifth request must stall.
        for (int d = 1; d <= 4; d++) xfer(DATA_W'(d));
        check("fill_level", 32'(level_o), 32'd4);
        check("fill_valid", 32'(valid_o), 32'd1);
        data_i = 32'h5;
        sb_q.push_back(32'h5);
        req_i = 1'b1;
        repeat (SYNC_N + 4) tick();
        check("full_no_ack", 32'(ack_o), 32'd0);
        check("full_level", 32'(level_o), 32'd4);

        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("pop_level", 32'(level_o), 32'd3);
        check("pop_same_edge_ack", 32'(ack_o), 32'd0);
        tick();
        check("late_ack", 32'(ack_o), 32'd1);
        check("late_level", 32'(level_o), 32'd4);
        req_i = 1'b0;
        wait_ack(1'b0, "late_ack_down");
        ready_i = 1'b1;
        wait_empty("drain_empty");
        ready_i = 1'b0;

        // Wrap-around with the consumer toggling ready_i every cycle.
        pops_before = pop_cnt;
        done = 1'b0;
        fork
            begin
                for (int d = 'h10; d <= 'h19; d++) xfer(DATA_W'(d));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    ready_i = ~ready_i;
                end
            end
        join
        ready_i = 1'b1;
        wait_empty("wrap_empty");
        check("wrap_count", 32'(pop_cnt - pops_before), 32'd10);
        check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
        ready_i = 1'b0;

        // Reset while ack_o=1 and req_i=1; the stale request must not be recaptured.
        data_i = 32'h77;
        req_i = 1'b1;
        wait_ack(1'b1, "rst_pre_ack");
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack_o), 32'd0);
        check("rst_mid_level", 32'(level_o), 32'd0);
        check("rst_mid_valid", 32'(valid_o), 32'd0);
        sb_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (12) tick();
        check("stale_no_ack", 32'(ack_o), 32'd0);
        check("stale_level", 32'(level_o), 32'd0);
        req_i = 1'b0;
        repeat (SYNC_N + 3) tick();
        check("stale_drop_ack", 32'(ack_o), 32'd0);
        ready_i = 1'b1;
        xfer(32'h88);
        wait_empty("post_rst_empty");
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
